sys_uart_tx: RTL and testbench



---
 rtl/sys_uart_tx.sv | 202 ++++++++++++++++++++
 tb/tb_sys_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_uart_tx.sv
// sys_uart_tx: console transmitter behind the syscall unit.
// Bytes written by the console-output syscall are queued in a small FIFO
// and serialised onto a UART TX line (idle high, start bit low, 8 data
// bits LSB first, optional even parity bit, stop bit high).
// Back-to-back frames go out with no idle gap while the FIFO holds data.
// Configuration macro: SYS_UART_TX_PARITY_EN adds an even-parity bit
// (11-bit frames). Without it, frames are plain 8N1 (10 bits).
module sys_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic [7:0] i_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_tx,
    output logic [7:0] o_drops
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SYS_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             wr_en;
    logic             pop;
    logic [7:0]       head;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] baud_q, baud_n;
    logic [2:0]       bit_q, bit_n;
    logic [7:0]       shift_q, shift_n;
    logic             tx_q, tx_n;
    logic             baud_wrap;
`ifdef SYS_UART_TX_PARITY_EN
    logic             parity_q, parity_n;
`endif

    // The extra pointer bit separates a full FIFO from an empty one.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign wr_en   = i_we & ~o_full;
    assign head    = mem[rd_ptr[FIFO_AW-1:0]];

    assign baud_wrap = (baud_q == CNT_LAST);
    assign o_tx      = tx_q;
    assign o_busy    = (state_q != ST_IDLE) | ~o_empty;

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= i_data;
        end
    end

    // FIFO pointers: a write while full never lands, even if a pop happens.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Saturating count of bytes discarded because the FIFO was full.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_drops <= 8'd0;
        end else if (i_we && o_full && (o_drops != 8'hFF)) begin
            o_drops <= o_drops + 8'd1;
        end
    end

    // Transmitter state register; the line level itself is registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
`ifdef SYS_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            baud_q   <= baud_n;
            bit_q    <= bit_n;
            shift_q  <= shift_n;
            tx_q     <= tx_n;
`ifdef SYS_UART_TX_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

    // Next-state logic: each bit lasts one full baud period and the line
    // only changes when the baud counter wraps (or on a pop from IDLE).
    always_comb begin
        state_n  = state_q;
        baud_n   = baud_wrap ? '0 : baud_q + CNT_W'(1);
        bit_n    = bit_q;
        shift_n  = shift_q;
        tx_n     = tx_q;
        pop      = 1'b0;
`ifdef SYS_UART_TX_PARITY_EN
        parity_n = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (!o_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
`ifdef SYS_UART_TX_PARITY_EN
                    parity_n = ^head;
`endif
                    state_n = ST_START;
                    tx_n    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    state_n = ST_DATA;
                    bit_n   = 3'd0;
                    tx_n    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef SYS_UART_TX_PARITY_EN
                        state_n = ST_PARITY;
                        tx_n    = parity_q;
`else
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        shift_n = {1'b0, shift_q[7:1]};
                        tx_n    = shift_q[1];
                        bit_n   = bit_q + 3'd1;
                    end
                end
            end
`ifdef SYS_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_wrap) begin
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_wrap) begin
                    if (!o_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
`ifdef SYS_UART_TX_PARITY_EN
                        parity_n = ^head;
`endif
                        state_n = ST_START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                baud_n  = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sys_uart_tx.sv
// Testbench for sys_uart_tx (CLKS_PER_BIT=4, FIFO_AW=2).
// Directed scenarios: reset, single frame, back-to-back frames, overflow,
// reset mid-frame and, when SYS_UART_TX_PARITY_EN is defined, parity frames.
module tb_sys_uart_tx;

    localparam int CPB = 4;
`ifdef SYS_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       we;
    logic [7:0] data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx;
    logic [7:0] drops;

    int testCount = 0;
    int failCount = 0;

    sys_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (2)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (we),
        .i_data (data),
        .o_full (full),
        .o_empty(empty),
        .o_busy (busy),
        .o_tx   (tx),
        .o_drops(drops)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte for exactly one rising edge, then drops the strobe.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        we   = 1'b1;
        data = b;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    // Checks a whole frame cycle by cycle; call at the negedge right after
    // the edge where the start bit begins. Returns one frame later.
    task automatic checkFrame(input logic [7:0] b);
        logic [10:0] bits;
        bits       = 11'h7FF;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
`ifdef SYS_UART_TX_PARITY_EN
        bits[9]    = ^b;
`endif
        checkOutput($sformatf("busy_in_frame_%02h", b), busy, 1);
        for (int k = 0; k < FRAME_BITS * CPB; k++) begin
            checkOutput($sformatf("tx_%02h_c%0d", b, k), tx, bits[k / CPB]);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] ovf [7];
        logic       lowSeen;
        ovf  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        rst  = 1'b1;
        we   = 1'b0;
        data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_drops", drops, 0);
        rst = 1'b0;

        // Single frame 0x41
        @(posedge clk);
        #1;
        applyStimulus(8'h41);
        @(negedge clk);
        checkOutput("single_empty", empty, 0);
        checkOutput("single_tx_pre", tx, 1);
        @(negedge clk);
        checkFrame(8'h41);
        checkOutput("single_busy_end", busy, 0);
        checkOutput("single_tx_end", tx, 1);
        checkOutput("single_empty_end", empty, 1);

        // Back-to-back 0x55, 0xAA, 0x0F
        @(posedge clk);
        #1;
        fork
            begin
                applyStimulus(8'h55);
                applyStimulus(8'hAA);
                applyStimulus(8'h0F);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                checkFrame(8'h55);
                checkOutput("b2b_empty_mid", empty, 0);
                checkFrame(8'hAA);
                checkOutput("b2b_empty_last", empty, 1);
                checkFrame(8'h0F);
            end
        join
        checkOutput("b2b_busy_end", busy, 0);

        // Overflow with a 4-deep FIFO
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    applyStimulus(ovf[i]);
                    if (i == 3) checkOutput("ovf_full_e3", full, 0);
                    if (i == 4) checkOutput("ovf_full_e4", full, 1);
                    if (i == 5) checkOutput("ovf_drops_e5", drops, 1);
                    if (i == 6) checkOutput("ovf_drops_e6", drops, 2);
                end
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                for (int i = 0; i < 5; i++) checkFrame(ovf[i]);
            end
        join
        checkOutput("ovf_empty_end", empty, 1);
        checkOutput("ovf_busy_end", busy, 0);
        checkOutput("ovf_drops_end", drops, 2);

        // Reset in the middle of data bit 3, with a second byte queued
        @(posedge clk);
        #1;
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        @(negedge clk);
        repeat (17) @(negedge clk);
        checkOutput("midrst_bit3", tx, 0);
        checkOutput("midrst_empty_pre", empty, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx", tx, 1);
        checkOutput("midrst_empty", empty, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_drops", drops, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lowSeen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!tx) lowSeen = 1'b1;
        end
        checkOutput("midrst_no_frame", lowSeen, 0);
        checkOutput("midrst_busy_after", busy, 0);

`ifdef SYS_UART_TX_PARITY_EN
        // Parity frames: 0x07 has odd weight, 0x03 even
        @(posedge clk);
        #1;
        applyStimulus(8'h07);
        @(negedge clk);
        @(negedge clk);
        checkFrame(8'h07);
        checkOutput("par07_busy_end", busy, 0);
        @(posedge clk);
        #1;
        applyStimulus(8'h03);
        @(negedge clk);
        @(negedge clk);
        checkFrame(8'h03);
        checkOutput("par03_busy_end", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
